// File: rtl/serial_word_compare.sv
// Sequential unsigned magnitude comparator: one 2-bit slice per clock, MSB first,
// stopping at the first slice that differs.
module serial_word_compare #(
  parameter int WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           res,
  output logic [$clog2(WIDTH/2+1)-1:0]         slices
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(NSLICE + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sa, sa_d, sb, sb_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [CW-1:0]    slices_d;
  logic [2:0]       res_d;
  logic             done_d;
  logic [1:0]       cmp;

  // Returns {gt, lt} for one 2-bit slice; both low means the slices are equal.
  function automatic logic [1:0] slice_cmp(input logic [1:0] x, input logic [1:0] y);
    slice_cmp = {x > y, x < y};
  endfunction

  assign cmp  = slice_cmp(sa[WIDTH-1 -: 2], sb[WIDTH-1 -: 2]);
  assign busy = (state == RUN);

  always_comb begin
    state_d  = state;
    sa_d     = sa;
    sb_d     = sb;
    cnt_d    = cnt;
    res_d    = res;
    slices_d = slices;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(NSLICE);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cmp != 2'b00) begin
          res_d    = {cmp[1], 1'b0, cmp[0]};
          slices_d = CW'(NSLICE) - cnt + CW'(1);
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt == CW'(1)) begin
          res_d    = 3'b010;
          slices_d = CW'(NSLICE);
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          sa_d  = sa << 2;
          sb_d  = sb << 2;
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      res    <= 3'b000;
      slices <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      sa     <= sa_d;
      sb     <= sb_d;
      cnt    <= cnt_d;
      res    <= res_d;
      slices <= slices_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_word_compare.sv
// Scoreboard bench for serial_word_compare: the driver queues expected results,
// a negedge monitor checks every done pulse against them.
module tb_serial_word_compare;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [2:0] res;
  logic [2:0] slices;

  typedef struct {
    logic [2:0] res;
    logic [2:0] slices;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  serial_word_compare #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .res(res), .slices(slices)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res", int'(res), int'(e.res));
        chk("slices", int'(slices), int'(e.slices));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; operands are accepted on the next edge.
  task automatic issue(input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] r, input logic [2:0] s, input int k);
    exp_t e;
    start = 1'b1;
    a     = x;
    b     = y;
    e.res = r; e.slices = s; e.cyc = cyc + 1 + k;
    sb_q.push_back(e);
    step(1);
    start = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] y,
                     input logic [2:0] r, input logic [2:0] s, input int k);
    issue(x, y, r, s, k);
    step(k + 1);
  endtask

  initial begin
    int c0;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    step(3);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_res", res, 0);
    chk("reset_slices", slices, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // 1: early decision, busy high for a single cycle
    issue(8'hA5, 8'h25, 3'b100, 3'd1, 1);
    @(negedge clk);
    chk("s1_busy_run", busy, 1);
    step(1);
    @(negedge clk);
    chk("s1_busy_done", busy, 0);
    chk("s1_done", done, 1);
    step(1);

    // 2: decision in the last slice
    run(8'h3C, 8'h3D, 3'b001, 3'd4, 4);

    // 3: equal operands
    run(8'h5A, 8'h5A, 3'b010, 3'd4, 4);
    run(8'h00, 8'h00, 3'b010, 3'd4, 4);
    run(8'hFF, 8'hFF, 3'b010, 3'd4, 4);

    // 4: start while busy is ignored
    issue(8'h01, 8'h02, 3'b001, 3'd4, 4);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    step(1);
    start = 1'b0;
    step(8);

    // 5: reset mid-operation with a coincident start, then a fresh compare
    start = 1'b1; a = 8'h03; b = 8'h02;
    step(1);
    start = 1'b0;
    step(1);
    rst = 1'b1; start = 1'b1;
    step(1);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("s5_busy", busy, 0);
    chk("s5_done", done, 0);
    chk("s5_res", res, 0);
    chk("s5_slices", slices, 0);
    step(6);
    @(negedge clk);
    chk("s5_idle_after_rst", busy, 0);
    step(1);
    run(8'h80, 8'h7F, 3'b100, 3'd1, 1);

    // 6: back-to-back with start held high
    issue(8'hC0, 8'h40, 3'b100, 3'd1, 1);
    start = 1'b1; a = 8'h11; b = 8'h11;
    c0 = cyc;
    begin
      exp_t e;
      e.res = 3'b010; e.slices = 3'd4; e.cyc = c0 + 6;
      sb_q.push_back(e);
    end
    @(negedge clk);
    chk("s6_busy_first", busy, 1);
    step(1);
    @(negedge clk);
    chk("s6_busy_gap", busy, 0);
    step(1);
    start = 1'b0;
    @(negedge clk);
    chk("s6_busy_second", busy, 1);
    step(6);

    chk("pending_results", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
